// File: rtl/cl_pkg.sv
// Shared definitions for the Camera Link frame emulator.
//   - default pixel width / tap count
//   - generator state and test-pattern enumerations
//   - packed shadow-configuration payload
//   - blanking counter load helper
package cl_pkg;

  localparam int unsigned CL_PIX_W_DEF = 8;
  localparam int unsigned CL_TAPS_DEF  = 2;
  localparam int unsigned CL_DIM_W     = 16;
  localparam int unsigned CL_BLANK_W   = 8;

  localparam logic [7:0] CL_CONST_PIX = 8'hA5;

  typedef enum logic [1:0] {
    CL_IDLE   = 2'd0,
    CL_FRONT  = 2'd1,
    CL_LINE   = 2'd2,
    CL_HBLANK = 2'd3
  } cl_gen_state_t;

  typedef enum logic [1:0] {
    CL_PAT_RAMP  = 2'd0,
    CL_PAT_CONST = 2'd1,
    CL_PAT_LINE  = 2'd2,
    CL_PAT_ZERO  = 2'd3
  } cl_pattern_t;

  // Frame geometry captured when a start request is sampled.
  typedef struct packed {
    logic [CL_DIM_W-1:0]   width;
    logic [CL_DIM_W-1:0]   height;
    logic [CL_BLANK_W-1:0] hblank;
    logic [CL_BLANK_W-1:0] vblank;
    cl_pattern_t           pattern;
  } cl_cfg_t;

  // Down-counter preload for a blanking period of max(len,1) cycles.
  function automatic logic [CL_BLANK_W-1:0] cl_blank_load(input logic [CL_BLANK_W-1:0] len);
    return (len == '0) ? '0 : len - CL_BLANK_W'(1);
  endfunction

endpackage

// File: rtl/cl_frame_generator_if.sv
// Control / video bus of the Camera Link frame emulator.
//   master : drives start/abort and geometry, receives framing and pixels
//   slave  : the generator itself
// Signals:
//   start, abort             one-cycle requests
//   image_width/height       beats per line / lines per frame
//   hblank, vblank           blanking lengths in cycles
//   pattern                  test-pattern select
//   fval, lval, dval         frame / line / data valid
//   pix_data                 TAPS*PIX_W pixel beat, tap 0 in LSBs
//   busy, frame_done, cfg_err status
interface cl_frame_generator_if #(
  parameter int unsigned PIX_W = cl_pkg::CL_PIX_W_DEF,
  parameter int unsigned TAPS  = cl_pkg::CL_TAPS_DEF
) ();

  localparam int unsigned BEAT_W = PIX_W * TAPS;

  logic                          start;
  logic                          abort;
  logic [cl_pkg::CL_DIM_W-1:0]   image_width;
  logic [cl_pkg::CL_DIM_W-1:0]   image_height;
  logic [cl_pkg::CL_BLANK_W-1:0] hblank;
  logic [cl_pkg::CL_BLANK_W-1:0] vblank;
  logic [1:0]                    pattern;

  logic                          fval;
  logic                          lval;
  logic                          dval;
  logic [BEAT_W-1:0]             pix_data;
  logic                          busy;
  logic                          frame_done;
  logic                          cfg_err;

  modport master (
    output start, abort, image_width, image_height, hblank, vblank, pattern,
    input  fval, lval, dval, pix_data, busy, frame_done, cfg_err
  );

  modport slave (
    input  start, abort, image_width, image_height, hblank, vblank, pattern,
    output fval, lval, dval, pix_data, busy, frame_done, cfg_err
  );

endinterface

// File: rtl/cl_pattern_gen.sv
// Combinational test-pattern mapper: (pattern, beat x, line y) -> one beat.
// Ports:
//   i_pattern  pattern select
//   i_x, i_y   beat and line index
//   o_beat_c   TAPS*PIX_W beat, tap 0 in LSBs (combinational)
module cl_pattern_gen #(
  parameter int unsigned PIX_W = cl_pkg::CL_PIX_W_DEF,
  parameter int unsigned TAPS  = cl_pkg::CL_TAPS_DEF
) (
  input  cl_pkg::cl_pattern_t          i_pattern,
  input  logic [cl_pkg::CL_DIM_W-1:0]  i_x,
  input  logic [cl_pkg::CL_DIM_W-1:0]  i_y,
  output logic [PIX_W*TAPS-1:0]        o_beat_c
);

  import cl_pkg::*;

  // Ramp arithmetic is done at 32 bits and truncated, giving mod 2^PIX_W.
  always_comb begin
    o_beat_c = '0;
    for (int t = 0; t < int'(TAPS); t++) begin
      case (i_pattern)
        CL_PAT_RAMP:  o_beat_c[t*PIX_W +: PIX_W] =
                        PIX_W'(32'(i_x) * 32'(TAPS) + 32'(t) + 32'(i_y));
        CL_PAT_CONST: o_beat_c[t*PIX_W +: PIX_W] = PIX_W'(CL_CONST_PIX);
        CL_PAT_LINE:  o_beat_c[t*PIX_W +: PIX_W] = PIX_W'(i_y);
        default:      o_beat_c[t*PIX_W +: PIX_W] = '0;
      endcase
    end
  end

endmodule

// File: rtl/cl_frame_generator.sv
// Camera Link transmitter-side frame emulator.
// Emits one FVAL/LVAL/DVAL-framed frame of multi-tap test pixels per start.
// Ports:
//   sys_clk    sole clock, rising edge
//   sys_rst_n  asynchronous active-low reset
//   bus        cl_frame_generator_if.slave (control in, framing/pixels out)
// Request/geometry inputs are sampled into a one-cycle request stage; the
// FSM acts on that stage one edge later, so every output appears two edges
// after the sampled start. All outputs are registered from next-state logic.
module cl_frame_generator #(
  parameter int unsigned PIX_W = cl_pkg::CL_PIX_W_DEF,
  parameter int unsigned TAPS  = cl_pkg::CL_TAPS_DEF
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  cl_frame_generator_if.slave    bus
);

  import cl_pkg::*;

  localparam int unsigned BEAT_W = PIX_W * TAPS;

  localparam logic [1:0] ST_IDLE   = 2'(CL_IDLE);
  localparam logic [1:0] ST_FRONT  = 2'(CL_FRONT);
  localparam logic [1:0] ST_LINE   = 2'(CL_LINE);
  localparam logic [1:0] ST_HBLANK = 2'(CL_HBLANK);

  logic [1:0]            r_state;
  logic [CL_DIM_W-1:0]   r_x;
  logic [CL_DIM_W-1:0]   r_y;
  logic [CL_BLANK_W-1:0] r_cnt;
  cl_cfg_t               r_cfg;
  logic                  r_start_q;

  logic                  r_fval;
  logic                  r_lval;
  logic [BEAT_W-1:0]     r_pix;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic [1:0]            w_state_nxt;
  logic [CL_DIM_W-1:0]   w_x_nxt;
  logic [CL_DIM_W-1:0]   w_y_nxt;
  logic [CL_BLANK_W-1:0] w_cnt_nxt;
  logic                  w_done_nxt;
  logic                  w_err_nxt;
  logic                  w_start_acc;
  logic                  w_last_beat;
  logic                  w_last_line;
  logic [BEAT_W-1:0]     w_beat;

  // A start is only taken while idle and not already pending; anything else
  // is dropped rather than queued.
  assign w_start_acc = bus.start & ~r_busy & ~r_start_q;

  assign w_last_beat = (r_x == r_cfg.width  - CL_DIM_W'(1));
  assign w_last_line = (r_y == r_cfg.height - CL_DIM_W'(1));

  // Next-state, counter and pulse logic.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (r_start_q) begin
          if (r_cfg.width == '0 || r_cfg.height == '0) begin
            w_err_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_FRONT;
            w_x_nxt     = '0;
            w_y_nxt     = '0;
            w_cnt_nxt   = cl_blank_load(r_cfg.vblank);
          end
        end
      end

      ST_FRONT: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_LINE;
          w_x_nxt     = '0;
        end else begin
          w_cnt_nxt = r_cnt - CL_BLANK_W'(1);
        end
      end

      ST_LINE: begin
        if (w_last_beat) begin
          if (w_last_line) begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_HBLANK;
            w_cnt_nxt   = cl_blank_load(r_cfg.hblank);
          end
        end else begin
          w_x_nxt = r_x + CL_DIM_W'(1);
        end
      end

      ST_HBLANK: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_LINE;
          w_x_nxt     = '0;
          w_y_nxt     = r_y + CL_DIM_W'(1);
        end else begin
          w_cnt_nxt = r_cnt - CL_BLANK_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Abort overrides everything except in IDLE, where a pending start wins.
    if (r_state != ST_IDLE && bus.abort) begin
      w_state_nxt = ST_IDLE;
      w_done_nxt  = 1'b0;
    end
  end

  // Pixel beat for the position the FSM is about to occupy.
  cl_pattern_gen #(
    .PIX_W (PIX_W),
    .TAPS  (TAPS)
  ) u_pattern (
    .i_pattern (r_cfg.pattern),
    .i_x       (w_x_nxt),
    .i_y       (w_y_nxt),
    .o_beat_c  (w_beat)
  );

  // State, shadow configuration and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_cnt     <= '0;
      r_cfg     <= '0;
      r_start_q <= 1'b0;
      r_fval    <= 1'b0;
      r_lval    <= 1'b0;
      r_pix     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_cnt     <= w_cnt_nxt;
      r_start_q <= w_start_acc;
      if (w_start_acc) begin
        r_cfg <= '{width:   bus.image_width,
                   height:  bus.image_height,
                   hblank:  bus.hblank,
                   vblank:  bus.vblank,
                   pattern: cl_pattern_t'(bus.pattern)};
      end
      r_fval <= (w_state_nxt != ST_IDLE);
      r_lval <= (w_state_nxt == ST_LINE);
      r_pix  <= (w_state_nxt == ST_LINE) ? w_beat : '0;
      r_busy <= (w_state_nxt != ST_IDLE);
      r_done <= w_done_nxt;
      r_err  <= w_err_nxt;
    end
  end

  assign bus.fval       = r_fval;
  assign bus.lval       = r_lval;
  assign bus.dval       = r_lval;
  assign bus.pix_data   = r_pix;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_done;
  assign bus.cfg_err    = r_err;

endmodule

// File: tb/tb_cl_frame_generator.sv
// Self-checking bench for cl_frame_generator (PIX_W=8, TAPS=2).
module tb_cl_frame_generator;

  localparam int unsigned PW = 8;
  localparam int unsigned TP = 2;

  typedef struct packed {
    logic        fval;
    logic        lval;
    logic        dval;
    logic [15:0] pix;
    logic        busy;
    logic        done;
    logic        err;
  } obs_t;

  typedef struct {
    int w, h, hb, vb, pat;
    int exp_len, exp_bursts, exp_done, exp_err;
    int exp_ffval, exp_flval, exp_ferr;
  } vec_t;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  cl_frame_generator_if #(.PIX_W(PW), .TAPS(TP)) bus ();

  cl_frame_generator #(.PIX_W(PW), .TAPS(TP)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t exp_q[$];
  logic [15:0] l1_beats[4];

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o = {bus.fval, bus.lval, bus.dval, bus.pix_data, bus.busy, bus.frame_done, bus.cfg_err};
    return o;
  endfunction

  task automatic check_obs(input string name, input int cyc, input obs_t got, input obs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got{f,l,d,pix,busy,done,err}=%b%b%b %h %b%b%b exp=%b%b%b %h %b%b%b",
               name, cyc, got.fval, got.lval, got.dval, got.pix, got.busy, got.done, got.err,
               exp.fval, exp.lval, exp.dval, exp.pix, exp.busy, exp.done, exp.err);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Spec-level pixel rule for one beat.
  function automatic logic [15:0] model_beat(input int pat, input int x, input int y);
    logic [15:0] b;
    int v;
    b = '0;
    for (int t = 0; t < int'(TP); t++) begin
      case (pat)
        0:       v = (x * int'(TP) + t + y) % 256;
        1:       v = 'hA5;
        2:       v = y % 256;
        default: v = 0;
      endcase
      b[t*8 +: 8] = 8'(v);
    end
    return b;
  endfunction

  // Expected per-cycle trace after the first active edge of a frame.
  task automatic build_model(input int w, input int h, input int hb, input int vb, input int pat);
    int vv, hh;
    vv = (vb == 0) ? 1 : vb;
    hh = (hb == 0) ? 1 : hb;
    exp_q.delete();
    repeat (vv) exp_q.push_back({1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0});
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++)
        exp_q.push_back({1'b1, 1'b1, 1'b1, model_beat(pat, x, y), 1'b1, 1'b0, 1'b0});
      if (y < h - 1)
        repeat (hh) exp_q.push_back({1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0});
    end
    exp_q.push_back({1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0});
  endtask

  task automatic set_cfg(input int w, input int h, input int hb, input int vb, input int pat);
    bus.image_width  = 16'(w);
    bus.image_height = 16'(h);
    bus.hblank       = 8'(hb);
    bus.vblank       = 8'(vb);
    bus.pattern      = 2'(pat);
  endtask

  // Emit one frame and compare every cycle with the model; with noise, the
  // geometry inputs are scrambled and stray starts are issued while busy.
  task automatic run_frame(input string name, input int w, input int h, input int hb,
                           input int vb, input int pat, input bit noise);
    obs_t got;
    bit   prev_busy;
    build_model(w, h, hb, vb, pat);
    set_cfg(w, h, hb, vb, pat);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    check_obs({name, "_accept"}, 0, sample(), '0);
    prev_busy = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (noise) begin
        set_cfg($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
                $urandom_range(0, 9), $urandom_range(0, 3));
        bus.start = (prev_busy && ($urandom_range(0, 3) == 0)) ? 1'b1 : 1'b0;
      end
      tick;
      bus.start = 1'b0;
      got = sample();
      check_obs(name, i + 1, got, exp_q[i]);
      prev_busy = exp_q[i].busy;
    end
  endtask

  // Measure framing statistics of one start request.
  task automatic measure(input vec_t v, output int len, output int bursts, output int dones,
                         output int errs, output int ffval, output int flval, output int ferr,
                         output int busy_cnt, output int dval_bad, output int timed_out);
    obs_t got;
    bit   prev_l, seen_busy;
    int   cur_burst, beat;
    len = 0; bursts = 0; dones = 0; errs = 0; busy_cnt = 0; dval_bad = 0;
    ffval = -1; flval = -1; ferr = -1; timed_out = 1;
    prev_l = 1'b0; seen_busy = 1'b0; beat = 0;
    set_cfg(v.w, v.h, v.hb, v.vb, v.pat);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      tick;
      got = sample();
      if (got.fval) begin len++; if (ffval < 0) ffval = c; end
      if (got.busy) begin busy_cnt++; seen_busy = 1'b1; end
      if (got.lval && flval < 0) flval = c;
      if (got.lval && !prev_l) bursts++;
      cur_burst = bursts;
      if (got.lval && cur_burst == 2 && beat < 4) begin l1_beats[beat] = got.pix; beat++; end
      if (got.dval != got.lval) dval_bad++;
      if (got.done) dones++;
      if (got.err) begin errs++; if (ferr < 0) ferr = c; end
      prev_l = got.lval;
      if (seen_busy && !got.busy) begin timed_out = 0; break; end
      if (!seen_busy && c >= 8) begin timed_out = 0; break; end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t vt[6];
    obs_t got;
    int len, bursts, dones, errs, ffval, flval, ferr, busy_cnt, dval_bad, timed_out;
    int falls, run, blen[2], cnt_f, cnt_d, cnt_b;
    bit prev_l, aborted, seen_l;

    vt[0] = '{4, 3, 2, 3, 0, 19, 3, 1, 0, 1, 4, -1};
    vt[1] = '{1, 2, 0, 0, 0,  4, 2, 1, 0, 1, 2, -1};
    vt[2] = '{0, 5, 1, 1, 0,  0, 0, 0, 1, -1, -1, 1};
    vt[3] = '{3, 0, 1, 1, 1,  0, 0, 0, 1, -1, -1, 1};
    vt[4] = '{2, 2, 1, 5, 1, 10, 2, 1, 0, 1, 6, -1};
    vt[5] = '{5, 1, 7, 1, 2,  6, 1, 1, 0, 1, 2, -1};

    bus.start = 1'b0;
    bus.abort = 1'b0;
    set_cfg(0, 0, 0, 0, 0);

    // Reset state
    repeat (3) tick;
    check_obs("reset_hold", 0, sample(), '0);
    sys_rst_n = 1'b1;
    tick;
    check_obs("reset_release", 0, sample(), '0);

    // Table-driven framing statistics
    foreach (vt[i]) begin
      measure(vt[i], len, bursts, dones, errs, ffval, flval, ferr, busy_cnt, dval_bad, timed_out);
      check_int($sformatf("v%0d_timeout", i), timed_out, 0);
      check_int($sformatf("v%0d_fval_len", i), len, vt[i].exp_len);
      check_int($sformatf("v%0d_busy_len", i), busy_cnt, vt[i].exp_len);
      check_int($sformatf("v%0d_bursts", i), bursts, vt[i].exp_bursts);
      check_int($sformatf("v%0d_done", i), dones, vt[i].exp_done);
      check_int($sformatf("v%0d_err", i), errs, vt[i].exp_err);
      check_int($sformatf("v%0d_first_fval", i), ffval, vt[i].exp_ffval);
      check_int($sformatf("v%0d_first_lval", i), flval, vt[i].exp_flval);
      check_int($sformatf("v%0d_first_err", i), ferr, vt[i].exp_ferr);
      check_int($sformatf("v%0d_dval", i), dval_bad, 0);
      if (i == 0) begin
        check_int("line1_beat0", int'(l1_beats[0]), 'h0201);
        check_int("line1_beat1", int'(l1_beats[1]), 'h0403);
        check_int("line1_beat2", int'(l1_beats[2]), 'h0605);
        check_int("line1_beat3", int'(l1_beats[3]), 'h0807);
      end
      repeat (2) tick;
    end

    // Full per-cycle model comparison of the reference frames
    run_frame("ramp_4x3", 4, 3, 2, 3, 0, 1'b0);
    tick;
    run_frame("min_1x2", 1, 2, 0, 0, 0, 1'b0);
    tick;

    // Abort in HBLANK after line 1, with an ignored mid-frame start
    set_cfg(4, 3, 3, 1, 0);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    falls = 0; run = 0; prev_l = 1'b0; aborted = 1'b0;
    blen[0] = 0; blen[1] = 0;
    for (int c = 0; c < 100 && !aborted; c++) begin
      tick;
      bus.start = 1'b0;
      got = sample();
      if (got.lval) run++;
      if (!got.lval && prev_l) begin
        if (falls < 2) blen[falls] = run;
        falls++;
        run = 0;
      end
      if (got.lval && run == 2 && falls == 0) begin
        set_cfg(1, 1, 0, 0, 3);
        bus.start = 1'b1;
      end
      if (falls == 2 && got.fval && !got.lval) begin
        bus.abort = 1'b1;
        tick;
        bus.abort = 1'b0;
        check_obs("abort_next_cycle", c, sample(), '0);
        aborted = 1'b1;
      end
      prev_l = got.lval;
    end
    check_int("abort_reached", int'(aborted), 1);
    check_int("abort_line0_len", blen[0], 4);
    check_int("abort_line1_len", blen[1], 4);
    cnt_f = 0; cnt_d = 0; cnt_b = 0;
    repeat (10) begin
      tick;
      got = sample();
      cnt_f += int'(got.fval);
      cnt_d += int'(got.done);
      cnt_b += int'(got.busy);
    end
    check_int("abort_no_fval", cnt_f, 0);
    check_int("abort_no_done", cnt_d, 0);
    check_int("abort_no_busy", cnt_b, 0);
    run_frame("after_abort", 4, 3, 3, 1, 0, 1'b0);
    tick;

    // Asynchronous reset during LINE
    set_cfg(6, 2, 1, 1, 0);
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    seen_l = 1'b0;
    for (int c = 0; c < 50 && !seen_l; c++) begin
      tick;
      seen_l = bus.lval;
    end
    check_int("rst_reached_line", int'(seen_l), 1);
    tick;
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_obs("rst_async", 0, sample(), '0);
    repeat (2) tick;
    sys_rst_n = 1'b1;
    tick;
    check_obs("rst_idle_after", 0, sample(), '0);
    run_frame("after_reset", 3, 2, 1, 2, 1, 1'b0);
    tick;

    // Randomized frames against the model
    for (int r = 0; r < 10; r++) begin
      run_frame($sformatf("rand%0d", r), $urandom_range(1, 6), $urandom_range(1, 5),
                $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3), 1'b1);
      repeat ($urandom_range(1, 3)) tick;
    end

    // Line-index wrap past 255, then back-to-back start
    run_frame("wrap_h300", 1, 300, 0, 0, 2, 1'b0);
    run_frame("back_to_back", 2, 2, 0, 1, 0, 1'b0);
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
